shift_ring_counter: RTL and testbench
=====================================

# shift_ring_counter

Parametrised ring/Johnson shift counter for one-hot and twisted-ring sequencing (phase selects, round-robin strobes, scan enables). It generalises the fixed 8-bit ring counter with:
- runtime mode and direction,
- enable and parallel load,
- an async reset,
- a wrap pulse,
- optional illegal-state self-correction.

It sits directly on the system clock and drives decode-free select lines.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..64
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  advance one step on this edge when high
- dir  input  1  0 = rotate left (toward MSB), 1 = rotate right (toward LSB)
- mode  input  1  0 = ring (one-hot), 1 = Johnson (twisted ring)
- load  input  1  parallel load of load_val on this edge
- load_val  input  WIDTH  value loaded when load=1
- count  output  WIDTH  current counter state
- wrap  output  1  one-cycle pulse: an enabled step just produced the mode seed
- err  output  1  one-cycle pulse: illegal state was corrected (0 when macro absent)

## Operation
- Seeds:
  - Ring seed = MSB only (1000…0).
  - Johnson seed = all zeros.
- Internal register mode_q holds the mode currently applied; it resets to 0 (ring).
- Step rules, using c = count:
  - Ring left: {c[W-2:0], c[W-1]}.
  - Ring right: {c[0], c[W-1:1]}.
  - Johnson left: {c[W-2:0], ~c[W-1]}.
  - Johnson right: {~c[0], c[W-1:1]}.
- Period:
  - Ring: WIDTH steps.
  - Johnson: 2*WIDTH steps.
  - Direction may change on any edge; the next step simply rotates the other way, with no reseed.
- Per-edge priority, highest first:
  1. rst
  2. mode change (mode != mode_q): count <= seed(mode), mode_q <= mode
  3. load: count <= load_val, taken verbatim
  4. self-correct (macro only)
  5. en: step
  6. hold
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: at most one bit set in c[W-1:1] ^ c[W-2:0] (2*WIDTH states).
- wrap:
  - Registered.
  - 1 in the cycle after an en step whose result equals seed(mode_q).
  - 0 after rst, load, mode change or correction, even if the resulting value equals the seed.
- err: registered; see Configuration.

## Timing
- Async reset: count = 1000…0, mode_q = 0, wrap = 0, err = 0, all immediately on rst assertion.
- Reset deassertion: the first edge with rst=0 may step, load or reseed normally.
- Latency:
  - All outputs are registered.
  - count reflects a step/load/reseed one edge after the controlling inputs are sampled.
  - wrap and err coincide with the count value that caused them.
- Simultaneous events:
  - load+en: load wins, no step.
  - mode change+load: reseed wins, load_val discarded.
  - mode change+en: reseed only.
- en=0 with no load/mode change: count, wrap=0, err=0 hold/clear as above. count holds.
- Reset mid-sequence: count returns to the ring seed asynchronously. A Johnson mode input then forces a Johnson reseed on the first edge.

## Configuration
- SHIFT_RING_COUNTER_SELFCORRECT_EN
  - Defined:
    - On an edge with no rst, mode change or load, an illegal count for mode_q is replaced by seed(mode_q), regardless of en.
    - err pulses for exactly that one cycle.
    - Correction takes one edge, so an illegally loaded value is visible for one cycle before correction.
  - Undefined:
    - No legality check; illegal patterns rotate unchanged.
    - err is tied to 0.

## Test plan
- WIDTH=4, ring, left, en=1 after reset: count 1000→0001→0010→0100→1000; wrap=1 only on the return to 1000, every 4 cycles.
- WIDTH=4, mode=1, left, en=1: first edge reseeds to 0000 with wrap=0; then 0001,0011,0111,1111,1110,1100,1000,0000 with wrap=1 on 0000; period 8.
- WIDTH=4, ring, dir toggled to 1 at count=0010: next values 0001, then 1000 with wrap=1; en=0 for 3 cycles holds 1000 and wrap=0.
- load=1, load_val=0100 together with en=1 in ring mode: count=0100 next cycle with no step; load asserted together with a mode change to Johnson yields count=0000.
- Macro defined, ring, load_val=0110: count=0110 for one cycle, then 1000 with err=1 for one cycle. Macro undefined: 0110→1100→1001→0011, err=0.
- rst asserted asynchronously mid-count (Johnson at 0111): count=1000, wrap=0 and err=0 before the next clk edge; with mode still 1, the first edge after release gives 0000.

Source files
------------

// File: rtl/shift_ring_counter.sv
// Ring / Johnson shift counter with load, direction and wrap pulse.
// Ports: clk, rst (async high), en, dir, mode, load, load_val -> count, wrap, err.
// Optional macro SHIFT_RING_COUNTER_SELFCORRECT_EN enables illegal-state
// correction with an err pulse; without it err is tied to 0.
module shift_ring_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_SEED =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] JOHN_SEED = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] step_val;

  assign seed_in = mode   ? JOHN_SEED : RING_SEED;
  assign seed_q  = mode_q ? JOHN_SEED : RING_SEED;

  always_comb begin
    step_val = count_q;
    unique case ({mode_q, dir})
      2'b00: step_val = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      2'b01: step_val = {count_q[0], count_q[WIDTH-1:1]};
      2'b10: step_val = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      2'b11: step_val = {~count_q[0], count_q[WIDTH-1:1]};
      default: step_val = count_q;
    endcase
  end

`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
  logic             err_q, err_d;
  logic             legal;
  logic [WIDTH-2:0] edges;

  // A Johnson state has at most one 0/1 boundary between neighbours.
  assign edges = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];

  always_comb begin
    if (mode_q) legal = ($countones(edges) <= 1);
    else        legal = ($countones(count_q) == 1);
  end
`endif

  always_comb begin
    count_d = count_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    err_d   = 1'b0;
`endif
    if (mode != mode_q) begin
      count_d = seed_in;
      mode_d  = mode;
    end else if (load) begin
      count_d = load_val;
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    end else if (!legal) begin
      count_d = seed_q;
      err_d   = 1'b1;
`endif
    end else if (en) begin
      count_d = step_val;
      wrap_d  = (step_val == seed_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RING_SEED;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Scoreboard bench for shift_ring_counter at WIDTH=4.
// Driver queues expected results; a monitor pops and checks per edge.
module tb_shift_ring_counter;

  typedef struct {
    logic [3:0] c;
    logic       w;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count;
  logic       wrap;
  logic       err;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   step_no = 0;

  shift_ring_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir),
    .mode(mode), .load(load), .load_val(load_val),
    .count(count), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step %0d: got %b want %b",
               nm, step_no, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      step_no++;
      chk("count", count, x.c);
      chk("wrap", {3'b0, wrap}, {3'b0, x.w});
      chk("err", {3'b0, err}, {3'b0, x.e});
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic drv(input logic e_i, input logic d_i,
                     input logic m_i, input logic l_i,
                     input logic [3:0] v_i, input logic [3:0] xc,
                     input logic xw, input logic xe);
    exp_t x;
    en = e_i; dir = d_i; mode = m_i;
    load = l_i; load_val = v_i;
    x.c = xc; x.w = xw; x.e = xe;
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_count", count, 4'b1000);
    chk("rst_wrap", {3'b0, wrap}, 4'b0);
    chk("rst_err", {3'b0, err}, 4'b0);
    @(negedge clk);
    rst = 1'b0;

    // ring left
    drv(1, 0, 0, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0010, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0100, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b1000, 1, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0010, 0, 0);
    // reverse at 0010, then hold
    drv(1, 1, 0, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 1, 0, 0, 4'h0, 4'b1000, 1, 0);
    drv(0, 1, 0, 0, 4'h0, 4'b1000, 0, 0);
    drv(0, 1, 0, 0, 4'h0, 4'b1000, 0, 0);
    drv(0, 1, 0, 0, 4'h0, 4'b1000, 0, 0);
    // load beats en; mode change beats load
    drv(1, 0, 0, 1, 4'b0100, 4'b0100, 0, 0);
    drv(1, 0, 1, 1, 4'b0110, 4'b0000, 0, 0);
    // Johnson left, full period
    drv(1, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0011, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0111, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b1111, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b1110, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b1100, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b1000, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0000, 1, 0);
    // Johnson right, then reseed to ring without wrap
    drv(1, 1, 1, 0, 4'h0, 4'b1000, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b1000, 0, 0);
    // loading the seed is not a wrap
    drv(0, 0, 0, 1, 4'b1000, 4'b1000, 0, 0);
    // illegal ring value
    drv(0, 0, 0, 1, 4'b0110, 4'b0110, 0, 0);
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    drv(1, 0, 0, 0, 4'h0, 4'b1000, 0, 1);
    drv(1, 0, 0, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0010, 0, 0);
`else
    drv(1, 0, 0, 0, 4'h0, 4'b1100, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b1001, 0, 0);
    drv(1, 0, 0, 0, 4'h0, 4'b0011, 0, 0);
`endif
    // Johnson to 0111, then async reset
    drv(1, 0, 1, 0, 4'h0, 4'b0000, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0001, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0011, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0111, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 4'b1000);
    chk("arst_wrap", {3'b0, wrap}, 4'b0);
    chk("arst_err", {3'b0, err}, 4'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(1, 0, 1, 0, 4'h0, 4'b0000, 0, 0);
    drv(1, 0, 1, 0, 4'h0, 4'b0001, 0, 0);

    repeat (4) if (q.size() > 0) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
